// File: rtl/pwm_actuator_driver.sv
// -----------------------------------------------------------------------------
// pwm_actuator_driver
//
// Actuator end of the control loop. Signed control words from the PID stage
// are clamped to [0, PERIOD] and double-buffered through a one-deep shadow
// register. The active duty only changes at a period boundary, or at once
// while the driver is disabled. A complementary half-bridge pair is driven
// with dead-time inserted on every transition between the high and low sides.
//
// Handshake: a cmd is taken on any rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_valid may be held across cycles while waiting.
// cmd_ready is high when the shadow is empty, or when the shadow is being
// moved into the active duty register in the current cycle.
//
// Ports
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high reset
//   enable       in   1      run enable; low = outputs off, counter held at 0
//   fault_in     in   1      power-stage fault; high forces both outputs low
//   cmd_valid    in   1      cmd is valid
//   cmd_ready    out  1      driver can accept cmd
//   cmd          in   WIDTH  signed duty request in counter cycles
//   pwm_hi       out  1      high-side gate drive (registered)
//   pwm_lo       out  1      low-side gate drive (registered)
//   period_start out  1      1-cycle pulse in the cycle where cnt wrapped to 0
//   duty_active  out  CNT_W  duty currently in use
//   sat_flag     out  1      last accepted cmd was clamped
//   fsm_state    out  3      current gate FSM state (debug visibility)
// -----------------------------------------------------------------------------
module pwm_actuator_driver #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 16,
    parameter int PERIOD = 1000,
    parameter int DEAD   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fault_in,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [WIDTH-1:0] cmd,
    output logic                    pwm_hi,
    output logic                    pwm_lo,
    output logic                    period_start,
    output logic [CNT_W-1:0]        duty_active,
    output logic                    sat_flag,
    output logic [2:0]              fsm_state
);

    // Wide enough to hold both operands plus a sign bit, so the clamp
    // compares correctly whichever of WIDTH / CNT_W is larger.
    localparam int EW = ((WIDTH > CNT_W) ? WIDTH : CNT_W) + 1;

    localparam logic [CNT_W-1:0]     LAST_CNT    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]     PERIOD_C    = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]     DEAD_RELOAD = CNT_W'(DEAD - 1);
    localparam logic signed [EW-1:0] PERIOD_X    = EW'(PERIOD);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DT_LO = 3'd1,
        LO    = 3'd2,
        DT_HI = 3'd3,
        HI    = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] dcnt_q;
    logic             pwm_hi_q, pwm_lo_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             shadow_full_q, shadow_full_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             sat_q, sat_d;
    logic             period_start_q;

    logic signed [EW-1:0] cmd_x;
    logic [CNT_W-1:0]     clamp_val;
    logic                 clamp_hit;
    logic                 wrap, load_now, accept, raw_hi;

    // ---------------- clamp ----------------
    assign cmd_x = {{(EW-WIDTH){cmd[WIDTH-1]}}, cmd};

    always_comb begin
        clamp_val = cmd_x[CNT_W-1:0];
        clamp_hit = 1'b0;
        if (cmd_x[EW-1]) begin
            clamp_val = '0;
            clamp_hit = 1'b1;
        end else if (cmd_x > PERIOD_X) begin
            clamp_val = PERIOD_C;
            clamp_hit = 1'b1;
        end
    end

    // ---------------- handshake / double buffer ----------------
    assign wrap      = enable && (cnt_q == LAST_CNT);
    // While disabled there is no period to protect, so the shadow drains at once.
    assign load_now  = shadow_full_q && (!enable || wrap);
    assign cmd_ready = !shadow_full_q || load_now;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        cnt_d         = enable ? (wrap ? '0 : cnt_q + 1'b1) : '0;
        duty_d        = duty_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        sat_d         = sat_q;
        if (load_now) begin
            duty_d        = shadow_q;
            shadow_full_d = 1'b0;
        end
        // Ordered after the load so a same-cycle accept refills the shadow.
        if (accept) begin
            shadow_d      = clamp_val;
            shadow_full_d = 1'b1;
            sat_d         = clamp_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            sat_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            sat_q          <= sat_d;
            period_start_q <= wrap;
        end
    end

    // ---------------- gate FSM ----------------
    assign raw_hi = (cnt_q < duty_q);

    // Outputs are assigned alongside the next state so both gate drives come
    // straight from flops. Defaults of 0 keep every unlisted path safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= OFF;
            dcnt_q   <= '0;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else begin
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
            if (fault_in || !enable) begin
                state_q <= OFF;
            end else begin
                case (state_q)
                    OFF: begin
                        state_q <= DT_LO;
                        dcnt_q  <= DEAD_RELOAD;
                    end
                    DT_LO: begin
                        if (dcnt_q == '0) begin
                            state_q  <= LO;
                            pwm_lo_q <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end
                    end
                    LO: begin
                        if (raw_hi) begin
                            state_q <= DT_HI;
                            dcnt_q  <= DEAD_RELOAD;
                        end else begin
                            pwm_lo_q <= 1'b1;
                        end
                    end
                    DT_HI: begin
                        // The high side never turned on, so returning to LO
                        // needs no further dead-time.
                        if (!raw_hi) begin
                            state_q  <= LO;
                            pwm_lo_q <= 1'b1;
                        end else if (dcnt_q == '0) begin
                            state_q  <= HI;
                            pwm_hi_q <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q - 1'b1;
                        end
                    end
                    HI: begin
                        if (!raw_hi) begin
                            state_q <= DT_LO;
                            dcnt_q  <= DEAD_RELOAD;
                        end else begin
                            pwm_hi_q <= 1'b1;
                        end
                    end
                    default: state_q <= OFF;
                endcase
            end
        end
    end

    assign pwm_hi       = pwm_hi_q;
    assign pwm_lo       = pwm_lo_q;
    assign period_start = period_start_q;
    assign duty_active  = duty_q;
    assign sat_flag     = sat_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_pwm_actuator_driver.sv
// -----------------------------------------------------------------------------
// tb_pwm_actuator_driver
//
// Directed bench for pwm_actuator_driver with PERIOD=10, DEAD=2, CNT_W=8,
// WIDTH=16. Inputs change and outputs are observed on the falling clk edge.
// Expected waveforms are written per counter phase (cnt 0..9), with the
// period_start pulse used as the cnt==0 reference.
// -----------------------------------------------------------------------------
module tb_pwm_actuator_driver;

    localparam int WIDTH  = 16;
    localparam int CNT_W  = 8;
    localparam int PERIOD = 10;
    localparam int DEAD   = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    fault_in;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic signed [WIDTH-1:0] cmd;
    logic                    pwm_hi;
    logic                    pwm_lo;
    logic                    period_start;
    logic [CNT_W-1:0]        duty_active;
    logic                    sat_flag;
    logic [2:0]              fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_actuator_driver #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .PERIOD(PERIOD),
        .DEAD  (DEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fault_in    (fault_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .period_start(period_start),
        .duty_active (duty_active),
        .sat_flag    (sat_flag),
        .fsm_state   (fsm_state)
    );

    // Shoot-through guard across every scenario.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (pwm_hi && pwm_lo) begin
                errors++;
                $display("FAIL overlap: hi=%b lo=%b at %0t, required not both 1", pwm_hi, pwm_lo, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the next cycle whose period_start is high (cnt==0).
    task automatic wait_ps();
        int n;
        n = 0;
        while (!period_start && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!period_start) begin
            errors++;
            $display("FAIL wait_ps: period_start=%b after %0d cycles, required 1", period_start, n);
        end
    endtask

    // Hold cmd_valid until the driver takes the word; returns one cycle after.
    task automatic send_cmd(input logic signed [WIDTH-1:0] v);
        int n;
        n = 0;
        cmd       = v;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_cmd: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; fault_in = 1'b0; cmd_valid = 1'b0; cmd = '0;
        step(); step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL reset_pwm: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", cmd_ready); end
        checks++; if (duty_active !== 8'd0) begin errors++; $display("FAIL reset_duty: %0d, required 0", duty_active); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: %b, required 0", period_start); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: %b, required 0", sat_flag); end
        reset = 1'b0;
        step();
        checks++; if ({pwm_hi, pwm_lo, period_start} !== 3'b000) begin errors++; $display("FAIL post_reset: hi/lo/ps=%b, required 000", {pwm_hi, pwm_lo, period_start}); end
    endtask

    task automatic test_steady();
        bit exp_hi [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        bit exp_lo [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        send_cmd(16'sd6);
        checks++; if (duty_active !== 8'd0) begin errors++; $display("FAIL steady_pre_load: duty=%0d, required 0", duty_active); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL steady_load_ready: %b, required 1", cmd_ready); end
        step();
        checks++; if (duty_active !== 8'd6) begin errors++; $display("FAIL steady_duty: %0d, required 6", duty_active); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL steady_sat: %b, required 0", sat_flag); end
        enable = 1'b1;
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL steady_dt1: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL steady_dt2: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo, period_start} !== 3'b010) begin errors++; $display("FAIL steady_first_lo: hi/lo/ps=%b, required 010", {pwm_hi, pwm_lo, period_start}); end
        wait_ps();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < PERIOD; k++) begin
                checks++;
                if ({pwm_hi, pwm_lo, period_start} !== {exp_hi[k], exp_lo[k], (k == 0)}) begin
                    errors++;
                    $display("FAIL steady_wave p%0d cnt%0d: hi/lo/ps=%b, required %b%b%b", p, k,
                             {pwm_hi, pwm_lo, period_start}, exp_hi[k], exp_lo[k], (k == 0));
                end
                step();
            end
        end
    endtask

    task automatic test_saturation();
        wait_ps();
        step(); step(); step();
        send_cmd(-16'sd5);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: %b, required 1", sat_flag); end
        checks++; if (duty_active !== 8'd6) begin errors++; $display("FAIL sat_neg_buffered: duty=%0d, required 6", duty_active); end
        repeat (5) step();
        checks++; if (duty_active !== 8'd6) begin errors++; $display("FAIL sat_neg_cnt9: duty=%0d, required 6", duty_active); end
        step();
        checks++; if ({period_start, duty_active} !== {1'b1, 8'd0}) begin errors++; $display("FAIL sat_neg_load: ps=%b duty=%0d, required 1 0", period_start, duty_active); end
        for (int k = 0; k < PERIOD; k++) begin
            checks++;
            if ({pwm_hi, pwm_lo} !== 2'b01) begin errors++; $display("FAIL sat_zero_wave cnt%0d: hi/lo=%b, required 01", k, {pwm_hi, pwm_lo}); end
            step();
        end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL sat_zero_ps: %b, required 1", period_start); end
        send_cmd(16'sd25);
        checks++; if ({sat_flag, duty_active} !== {1'b1, 8'd0}) begin errors++; $display("FAIL sat_hi_accept: sat=%b duty=%0d, required 1 0", sat_flag, duty_active); end
        wait_ps();
        checks++; if (duty_active !== 8'd10) begin errors++; $display("FAIL sat_hi_duty: %0d, required 10", duty_active); end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < PERIOD; k++) begin
                checks++;
                if ({pwm_hi, pwm_lo} !== {(p > 0 || k >= 3), (p == 0 && k == 0)}) begin
                    errors++;
                    $display("FAIL sat_full_wave p%0d cnt%0d: hi/lo=%b, required %b%b", p, k,
                             {pwm_hi, pwm_lo}, (p > 0 || k >= 3), (p == 0 && k == 0));
                end
                step();
            end
        end
    endtask

    task automatic test_fault();
        // Entered at cnt0 with duty 10, so the driver sits in HI.
        checks++; if ({pwm_hi, period_start} !== 2'b11) begin errors++; $display("FAIL fault_pre: hi/ps=%b, required 11", {pwm_hi, period_start}); end
        fault_in = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL fault_held cnt%0d: hi/lo=%b, required 00", k, {pwm_hi, pwm_lo}); end
        end
        fault_in = 1'b0;
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL fault_dt1: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL fault_dt2: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b01) begin errors++; $display("FAIL fault_lo: hi/lo=%b, required 01", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL fault_dthi1: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL fault_dthi2: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b10) begin errors++; $display("FAIL fault_hi: hi/lo=%b, required 10", {pwm_hi, pwm_lo}); end
        step();
        checks++; if ({pwm_hi, period_start} !== 2'b11) begin errors++; $display("FAIL fault_wrap: hi/ps=%b, required 11", {pwm_hi, period_start}); end
    endtask

    task automatic test_back_to_back();
        step(); step();
        cmd = 16'sd3; cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: %b, required 1", cmd_ready); end
        step();
        cmd = 16'sd7;
        for (int k = 3; k < PERIOD - 1; k++) begin
            checks++;
            if ({cmd_ready, duty_active} !== {1'b0, 8'd10}) begin
                errors++;
                $display("FAIL b2b_blocked cnt%0d: ready=%b duty=%0d, required 0 10", k, cmd_ready, duty_active);
            end
            step();
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cnt9_ready: %b, required 1", cmd_ready); end
        step();
        checks++; if ({period_start, cmd_ready, duty_active} !== {2'b10, 8'd3}) begin errors++; $display("FAIL b2b_wrap1: ps=%b ready=%b duty=%0d, required 1 0 3", period_start, cmd_ready, duty_active); end
        cmd_valid = 1'b0;
        repeat (9) step();
        checks++; if ({cmd_ready, duty_active} !== {1'b1, 8'd3}) begin errors++; $display("FAIL b2b_cnt9b: ready=%b duty=%0d, required 1 3", cmd_ready, duty_active); end
        step();
        checks++; if ({period_start, cmd_ready, sat_flag, duty_active} !== {3'b110, 8'd7}) begin errors++; $display("FAIL b2b_wrap2: ps=%b ready=%b sat=%b duty=%0d, required 1 1 0 7", period_start, cmd_ready, sat_flag, duty_active); end
    endtask

    task automatic test_below_dead();
        send_cmd(16'sd1);
        wait_ps();
        checks++; if (duty_active !== 8'd1) begin errors++; $display("FAIL bd_duty: %0d, required 1", duty_active); end
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < PERIOD; k++) begin
                checks++;
                if ({pwm_hi, pwm_lo} !== {1'b0, (k != 1)}) begin
                    errors++;
                    $display("FAIL bd_wave p%0d cnt%0d: hi/lo=%b, required 0%b", p, k, {pwm_hi, pwm_lo}, (k != 1));
                end
                step();
            end
        end
    endtask

    task automatic test_reset_in_hi();
        send_cmd(16'sd25);
        wait_ps();
        checks++; if (duty_active !== 8'd10) begin errors++; $display("FAIL rst_hi_duty: %0d, required 10", duty_active); end
        step(); step(); step();
        checks++; if ({pwm_hi, pwm_lo} !== 2'b10) begin errors++; $display("FAIL rst_hi_pre: hi/lo=%b, required 10", {pwm_hi, pwm_lo}); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({pwm_hi, pwm_lo} !== 2'b00) begin errors++; $display("FAIL rst_hi_pwm: hi/lo=%b, required 00", {pwm_hi, pwm_lo}); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_hi_ready: %b, required 1", cmd_ready); end
        checks++; if ({duty_active, sat_flag, period_start} !== {8'd0, 2'b00}) begin errors++; $display("FAIL rst_hi_regs: duty=%0d sat=%b ps=%b, required 0 0 0", duty_active, sat_flag, period_start); end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_steady();
        test_saturation();
        test_fault();
        test_back_to_back();
        test_below_dead();
        test_reset_in_hi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
